// File: rtl/hgcal_pkg.sv
// Shared definitions for the HGCAL layer-0 front end: default frame geometry,
// lane type and the frame-assembly FSM states.
package hgcal_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int IN_W_DEF  = 8;
    localparam int Q_W_DEF   = 2;
    localparam int SHIFT_DEF = 4;

    typedef logic [Q_W_DEF-1:0] lane_t;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        COLLECT    = 1'b1
    } state_t;

endpackage

// File: rtl/input_quantiser.sv
// Maps one signed raw sample onto an unsigned Q_W-bit lane value: negatives clamp
// to zero, positives are shifted down and saturated, with no rounding.
module input_quantiser #(
    parameter int IN_W  = 8,
    parameter int Q_W   = 2,
    parameter int SHIFT = 4
) (
    input  logic [IN_W-1:0] s_data,
    output logic [Q_W-1:0]  q
);

    localparam logic [IN_W-1:0] QMAX = IN_W'((1 << Q_W) - 1);

    logic [IN_W-1:0] shifted;

    // Only non-negative samples reach the shifter, so a logical shift is exact.
    always_comb begin
        shifted = s_data >> SHIFT;
        if (s_data[IN_W-1]) begin
            q = '0;
        end else if (shifted > QMAX) begin
            q = '1;
        end else begin
            q = shifted[Q_W-1:0];
        end
    end

endmodule

// File: rtl/layer0_input_assembler.sv
// Collects a serial stream of quantised samples into one N_IN-lane frame and hands
// it to the layer-1 bus through a registered valid/ready output stage.
module layer0_input_assembler
    import hgcal_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int Q_W   = Q_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_first,
    input  logic [IN_W-1:0]       s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [N_IN*Q_W-1:0]   m_vec,
    output logic                  err_pulse,
    output logic [7:0]            err_cnt
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int POS_W = (N_IN * Q_W > 1) ? $clog2(N_IN * Q_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic [IDX_W-1:0]     wr_idx;
    logic [POS_W-1:0]     wr_pos;
    logic                 ready_en;
    logic [Q_W-1:0]       q;
    logic [N_IN*Q_W-1:0]  asm_vec;
    logic [N_IN*Q_W-1:0]  frame_vec;
    logic                 accept;
    logic                 last_slot;
    logic                 do_write;
    logic                 do_start;
    logic                 do_complete;
    logic                 do_err;

    input_quantiser #(
        .IN_W  (IN_W),
        .Q_W   (Q_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .s_data (s_data),
        .q      (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_FIRST;
        end else begin
            state <= state_next;
        end
    end

    // The frame's final sample may only enter when the output register is free,
    // so the stall is confined to that one slot.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        do_write    = 1'b0;
        do_start    = 1'b0;
        do_complete = 1'b0;
        do_err      = 1'b0;
        last_slot   = (state == COLLECT) ? (idx == LAST_IDX) : (N_IN == 1);
        s_ready     = ready_en && !(last_slot && m_valid && !m_ready);
        accept      = s_valid && s_ready;
        if (accept) begin
            case (state)
                WAIT_FIRST: begin
                    if (s_first) begin
                        do_write = 1'b1;
                        do_start = 1'b1;
                        if (N_IN == 1) begin
                            do_complete = 1'b1;
                        end else begin
                            idx_next   = IDX_W'(1);
                            state_next = COLLECT;
                        end
                    end else begin
                        do_err = 1'b1;
                    end
                end
                COLLECT: begin
                    do_write = 1'b1;
                    if (s_first) begin
                        do_start = 1'b1;
                        do_err   = 1'b1;
                        idx_next = IDX_W'(1);
                    end else if (idx == LAST_IDX) begin
                        do_complete = 1'b1;
                        idx_next    = '0;
                        state_next  = WAIT_FIRST;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
                default: state_next = WAIT_FIRST;
            endcase
        end
    end

    // A new frame starts from cleared lanes so nothing of an aborted frame leaks through.
    always_comb begin
        wr_idx    = do_start ? '0 : idx;
        wr_pos    = POS_W'(wr_idx * Q_W);
        frame_vec = do_start ? '0 : asm_vec;
        frame_vec[wr_pos +: Q_W] = q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            ready_en  <= 1'b0;
            asm_vec   <= '0;
            m_vec     <= '0;
            m_valid   <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            idx      <= idx_next;
            ready_en <= 1'b1;
            if (do_complete) begin
                asm_vec <= '0;
            end else if (do_write) begin
                asm_vec <= frame_vec;
            end
            if (do_complete) begin
                m_vec   <= frame_vec;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            err_pulse <= do_err;
            if (do_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
